// File: rtl/branch_pkg.sv
// Shared types for the branch redirect controller: decoded branch types and
// redirect sequencer states.
package branch_pkg;

  typedef enum logic [2:0] {
    BR_BEQ  = 3'b000,
    BR_BNE  = 3'b001,
    BR_NONE = 3'b010,
    BR_JUMP = 3'b011,
    BR_BLT  = 3'b100,
    BR_BGE  = 3'b101,
    BR_BLTU = 3'b110,
    BR_BGEU = 3'b111
  } br_type_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REDIR  = 2'd2,
    SQUASH = 2'd3
  } redir_state_e;

  // Conditional branches are every encoding except jump and "not a branch".
  function automatic logic is_cond_branch(input br_type_e t);
    return (t != BR_JUMP) && (t != BR_NONE);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Increment-enable counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Turns the EX-stage branch decision into a registered PC redirect, pipeline
// flush and fetch squash window, and keeps saturating branch statistics.
//
//   state  | meaning
//   IDLE   | watching EX for a taken branch or jump
//   HOLD   | redirect latched, waiting for the LSU stall to clear
//   REDIR  | pc_redirect_o/flush_o asserted (held across stalls)
//   SQUASH | fetched instructions are wrong-path; fetch_squash_o asserted
module branch_redirect_ctrl
  import branch_pkg::*;
#(
  parameter int SQUASH_CYCLES = 1,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid_i,
  input  logic [2:0]       ex_br_type_i,
  input  logic             ex_br_taken_i,
  input  logic [31:0]      ex_target_i,
  input  logic             stall_i,
  output logic             pc_redirect_o,
  output logic [31:0]      pc_target_o,
  output logic             flush_o,
  output logic             fetch_squash_o,
  output logic [CNT_W-1:0] cnt_branches_o,
  output logic [CNT_W-1:0] cnt_taken_o,
  output logic [CNT_W-1:0] cnt_jumps_o
);

  redir_state_e state_q, state_d;
  logic [31:0]  target_q, target_d;
  logic [2:0]   sq_cnt_q, sq_cnt_d;
  logic         counted_q, counted_d;
  logic         redirect_q, redirect_d;
  logic         flush_q, flush_d;
  logic         squash_q, squash_d;

  br_type_e br_type;
  logic     resolve;
  logic     taken;
  logic     count_en;

  assign br_type  = br_type_e'(ex_br_type_i);
  assign resolve  = ex_valid_i && (br_type != BR_NONE) && (state_q != SQUASH);
  assign taken    = ex_br_taken_i || (br_type == BR_JUMP);
  // A stalled instruction sits in EX for many cycles; count it only once.
  assign count_en = resolve && (state_q == IDLE) && !counted_q;

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    sq_cnt_d  = sq_cnt_q;
    counted_d = stall_i && (counted_q || (resolve && (state_q == IDLE)));
    case (state_q)
      IDLE: begin
        if (resolve && taken) begin
          target_d = ex_target_i;
          state_d  = stall_i ? HOLD : REDIR;
        end
      end
      HOLD: begin
        if (!stall_i) state_d = REDIR;
      end
      REDIR: begin
        if (!stall_i) begin
          if (SQUASH_CYCLES > 0) begin
            state_d  = SQUASH;
            sq_cnt_d = 3'(SQUASH_CYCLES);
          end else begin
            state_d = IDLE;
          end
        end
      end
      SQUASH: begin
        if (!stall_i) begin
          if (sq_cnt_q <= 3'd1) state_d = IDLE;
          else                  sq_cnt_d = sq_cnt_q - 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    redirect_d = (state_d == REDIR);
    flush_d    = (state_d == REDIR);
    squash_d   = (state_d == SQUASH);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      target_q   <= '0;
      sq_cnt_q   <= '0;
      counted_q  <= 1'b0;
      redirect_q <= 1'b0;
      flush_q    <= 1'b0;
      squash_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      sq_cnt_q   <= sq_cnt_d;
      counted_q  <= counted_d;
      redirect_q <= redirect_d;
      flush_q    <= flush_d;
      squash_q   <= squash_d;
    end
  end

  assign pc_redirect_o  = redirect_q;
  assign flush_o        = flush_q;
  assign fetch_squash_o = squash_q;
  assign pc_target_o    = target_q;

  sat_counter #(.W(CNT_W)) u_cnt_branches (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (count_en && is_cond_branch(br_type)),
    .cnt_o (cnt_branches_o)
  );

  sat_counter #(.W(CNT_W)) u_cnt_taken (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (count_en && is_cond_branch(br_type) && ex_br_taken_i),
    .cnt_o (cnt_taken_o)
  );

  sat_counter #(.W(CNT_W)) u_cnt_jumps (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (count_en && (br_type == BR_JUMP)),
    .cnt_o (cnt_jumps_o)
  );

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Bench for branch_redirect_ctrl: directed scenarios plus a randomized run
// checked against a transaction-level reference model.
module tb_branch_redirect_ctrl;

  localparam int SQ    = 1;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             ex_valid_i;
  logic [2:0]       ex_br_type_i;
  logic             ex_br_taken_i;
  logic [31:0]      ex_target_i;
  logic             stall_i;
  logic             pc_redirect_o;
  logic [31:0]      pc_target_o;
  logic             flush_o;
  logic             fetch_squash_o;
  logic [CNT_W-1:0] cnt_branches_o;
  logic [CNT_W-1:0] cnt_taken_o;
  logic [CNT_W-1:0] cnt_jumps_o;

  int n_checks = 0;
  int n_errors = 0;

  branch_redirect_ctrl #(.SQUASH_CYCLES(SQ), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ex_valid_i     (ex_valid_i),
    .ex_br_type_i   (ex_br_type_i),
    .ex_br_taken_i  (ex_br_taken_i),
    .ex_target_i    (ex_target_i),
    .stall_i        (stall_i),
    .pc_redirect_o  (pc_redirect_o),
    .pc_target_o    (pc_target_o),
    .flush_o        (flush_o),
    .fetch_squash_o (fetch_squash_o),
    .cnt_branches_o (cnt_branches_o),
    .cnt_taken_o    (cnt_taken_o),
    .cnt_jumps_o    (cnt_jumps_o)
  );

  always #5 clk = ~clk;

  // Reference model: a pending redirect moves through "waiting for stall to
  // clear" -> "redirect visible" -> a squash window of SQ cycles.
  bit          m_wait, m_redir, m_counted;
  int          m_squash_left;
  logic [31:0] m_target;
  int          m_br, m_tk, m_jp;

  function automatic int sat_inc(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic model_step(input bit rst, input bit v, input logic [2:0] t,
                            input bit tk, input logic [31:0] tg, input bit st);
    bit busy, res, tkn, cnt_next;
    if (!rst) begin
      m_wait = 0; m_redir = 0; m_counted = 0; m_squash_left = 0;
      m_target = 0; m_br = 0; m_tk = 0; m_jp = 0;
      return;
    end
    busy     = m_wait || m_redir || (m_squash_left > 0);
    res      = v && (t != 3'b010) && (m_squash_left == 0);
    tkn      = tk || (t == 3'b011);
    cnt_next = st && (m_counted || (!busy && res));
    if (!busy && res && !m_counted) begin
      if (t == 3'b011) m_jp = sat_inc(m_jp);
      else begin
        m_br = sat_inc(m_br);
        if (tk) m_tk = sat_inc(m_tk);
      end
    end
    if (m_redir) begin
      if (!st) begin m_redir = 0; m_squash_left = SQ; end
    end else if (m_wait) begin
      if (!st) begin m_wait = 0; m_redir = 1; end
    end else if (m_squash_left > 0) begin
      if (!st) m_squash_left--;
    end else if (res && tkn) begin
      m_target = tg;
      if (st) m_wait = 1; else m_redir = 1;
    end
    m_counted = cnt_next;
  endtask

  task automatic drive(input bit v, input logic [2:0] t, input bit tk,
                       input logic [31:0] tg, input bit st);
    ex_valid_i = v; ex_br_type_i = t; ex_br_taken_i = tk;
    ex_target_i = tg; stall_i = st;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 3'b010, 0, 32'h0, 0);
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1, 3'b000, 1, 32'hDEAD_BEEF, 0);
    tick();
    n_checks++; if ({pc_redirect_o, flush_o, fetch_squash_o} !== 3'b000) begin n_errors++; $display("FAIL reset_outs got=%b exp=000", {pc_redirect_o, flush_o, fetch_squash_o}); end
    n_checks++; if (pc_target_o !== 32'h0) begin n_errors++; $display("FAIL reset_target got=%h exp=0", pc_target_o); end
    n_checks++; if ({cnt_branches_o, cnt_taken_o, cnt_jumps_o} !== '0) begin n_errors++; $display("FAIL reset_cnts got=%h/%h/%h exp=0", cnt_branches_o, cnt_taken_o, cnt_jumps_o); end
    rst_n = 1'b1;
  endtask

  task automatic test_taken_beq();
    do_reset();
    drive(1, 3'b000, 1, 32'h40, 0);
    tick();
    n_checks++; if ({pc_redirect_o, flush_o, fetch_squash_o} !== 3'b110) begin n_errors++; $display("FAIL beq_redir got=%b exp=110", {pc_redirect_o, flush_o, fetch_squash_o}); end
    n_checks++; if (pc_target_o !== 32'h40) begin n_errors++; $display("FAIL beq_target got=%h exp=40", pc_target_o); end
    n_checks++; if (cnt_taken_o !== 4'd1 || cnt_branches_o !== 4'd1) begin n_errors++; $display("FAIL beq_cnt got=%0d/%0d exp=1/1", cnt_taken_o, cnt_branches_o); end
    drive(0, 3'b010, 0, 32'h0, 0);
    tick();
    n_checks++; if ({pc_redirect_o, flush_o, fetch_squash_o} !== 3'b001) begin n_errors++; $display("FAIL beq_squash got=%b exp=001", {pc_redirect_o, flush_o, fetch_squash_o}); end
    // Wrong-path taken branch during squash must be ignored.
    drive(1, 3'b000, 1, 32'h999, 0);
    tick();
    n_checks++; if ({pc_redirect_o, flush_o, fetch_squash_o} !== 3'b000) begin n_errors++; $display("FAIL squash_ignore got=%b exp=000", {pc_redirect_o, flush_o, fetch_squash_o}); end
    n_checks++; if (cnt_branches_o !== 4'd1) begin n_errors++; $display("FAIL squash_nocount got=%0d exp=1", cnt_branches_o); end
    drive(0, 3'b010, 0, 32'h0, 0);
  endtask

  task automatic test_not_taken();
    do_reset();
    drive(1, 3'b001, 0, 32'h80, 0);
    tick();
    n_checks++; if ({pc_redirect_o, flush_o} !== 2'b00) begin n_errors++; $display("FAIL bne_noredir got=%b exp=00", {pc_redirect_o, flush_o}); end
    n_checks++; if (cnt_branches_o !== 4'd1 || cnt_taken_o !== 4'd0) begin n_errors++; $display("FAIL bne_cnt got=%0d/%0d exp=1/0", cnt_branches_o, cnt_taken_o); end
    // Not-taken blt held in EX by a 3-cycle stall counts once; type 010 never counts.
    drive(1, 3'b100, 0, 32'h0, 1);
    repeat (3) tick();
    drive(1, 3'b100, 0, 32'h0, 0);
    tick();
    drive(1, 3'b010, 1, 32'h123, 0);
    tick();
    n_checks++; if (cnt_branches_o !== 4'd2) begin n_errors++; $display("FAIL stall_count_once got=%0d exp=2", cnt_branches_o); end
    n_checks++; if ({pc_redirect_o, flush_o} !== 2'b00) begin n_errors++; $display("FAIL none_noredir got=%b exp=00", {pc_redirect_o, flush_o}); end
    drive(0, 3'b010, 0, 32'h0, 0);
  endtask

  task automatic test_jump_stall();
    do_reset();
    drive(1, 3'b011, 1, 32'h100, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if ({pc_redirect_o, flush_o, fetch_squash_o} !== 3'b000) begin n_errors++; $display("FAIL jump_hold_outs cyc=%0d got=%b exp=000", i, {pc_redirect_o, flush_o, fetch_squash_o}); end
    end
    drive(1, 3'b011, 1, 32'h100, 0);
    tick();
    n_checks++; if ({pc_redirect_o, flush_o} !== 2'b11 || pc_target_o !== 32'h100) begin n_errors++; $display("FAIL jump_redir got=%b tgt=%h exp=11 tgt=100", {pc_redirect_o, flush_o}, pc_target_o); end
    n_checks++; if (cnt_jumps_o !== 4'd1 || cnt_branches_o !== 4'd0) begin n_errors++; $display("FAIL jump_cnt got=%0d/%0d exp=1/0", cnt_jumps_o, cnt_branches_o); end
    drive(0, 3'b010, 0, 32'h0, 0);
    tick();
    n_checks++; if ({pc_redirect_o, fetch_squash_o} !== 2'b01) begin n_errors++; $display("FAIL jump_squash got=%b exp=01", {pc_redirect_o, fetch_squash_o}); end
  endtask

  task automatic test_redir_stall();
    do_reset();
    drive(1, 3'b101, 1, 32'h2000, 0);
    tick();
    drive(0, 3'b010, 0, 32'h0, 1);
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++; if ({pc_redirect_o, flush_o, fetch_squash_o} !== 3'b110 || pc_target_o !== 32'h2000) begin n_errors++; $display("FAIL redir_held cyc=%0d got=%b tgt=%h exp=110 tgt=2000", i, {pc_redirect_o, flush_o, fetch_squash_o}, pc_target_o); end
    end
    drive(0, 3'b010, 0, 32'h0, 0);
    tick();
    n_checks++; if ({pc_redirect_o, flush_o, fetch_squash_o} !== 3'b001) begin n_errors++; $display("FAIL redir_release got=%b exp=001", {pc_redirect_o, flush_o, fetch_squash_o}); end
    tick();
  endtask

  task automatic test_reset_in_squash();
    do_reset();
    drive(1, 3'b110, 1, 32'h3000, 0);
    tick();
    drive(0, 3'b010, 0, 32'h0, 0);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_checks++; if ({pc_redirect_o, flush_o, fetch_squash_o} !== 3'b000 || {cnt_branches_o, cnt_taken_o} !== '0) begin n_errors++; $display("FAIL rst_squash got=%b cnt=%0d/%0d exp=000 cnt=0/0", {pc_redirect_o, flush_o, fetch_squash_o}, cnt_branches_o, cnt_taken_o); end
    drive(1, 3'b111, 1, 32'h80, 0);
    tick();
    n_checks++; if ({pc_redirect_o, flush_o} !== 2'b11 || pc_target_o !== 32'h80 || cnt_taken_o !== 4'd1) begin n_errors++; $display("FAIL post_rst_branch got=%b tgt=%h taken=%0d exp=11 tgt=80 taken=1", {pc_redirect_o, flush_o}, pc_target_o, cnt_taken_o); end
    drive(0, 3'b010, 0, 32'h0, 0);
    repeat (2) tick();
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < CMAX + 2; i++) begin
      drive(1, 3'b000, 1, 32'(i * 4), 0);
      tick();
      drive(0, 3'b010, 0, 32'h0, 0);
      repeat (2) tick();
      if (i == CMAX - 1) begin
        n_checks++; if (cnt_taken_o !== 4'hF) begin n_errors++; $display("FAIL sat_reach got=%h exp=f", cnt_taken_o); end
      end
    end
    n_checks++; if (cnt_taken_o !== 4'hF || cnt_branches_o !== 4'hF) begin n_errors++; $display("FAIL sat_hold got=%h/%h exp=f/f", cnt_taken_o, cnt_branches_o); end
  endtask

  task automatic test_random();
    bit          v, tk, st, rs;
    logic [2:0]  t;
    logic [31:0] tg;
    do_reset();
    model_step(0, 0, 3'b010, 0, 32'h0, 0);
    for (int i = 0; i < 3000; i++) begin
      rs = ($urandom_range(0, 199) != 0);
      v  = ($urandom_range(0, 9) < 7);
      t  = 3'($urandom_range(0, 7));
      tk = (t == 3'b011) ? 1'b1 : 1'($urandom_range(0, 1));
      st = ($urandom_range(0, 9) < 3);
      tg = $urandom;
      rst_n = rs;
      drive(v, t, tk, tg, st);
      tick();
      model_step(rs, v, t, tk, tg, st);
      n_checks++; if (pc_redirect_o !== m_redir || flush_o !== m_redir || fetch_squash_o !== (m_squash_left > 0)) begin n_errors++; $display("FAIL rnd_outs cyc=%0d got=%b%b%b exp=%b%b%b", i, pc_redirect_o, flush_o, fetch_squash_o, m_redir, m_redir, m_squash_left > 0); end
      if (m_redir || m_wait) begin
        n_checks++; if (pc_target_o !== m_target) begin n_errors++; $display("FAIL rnd_target cyc=%0d got=%h exp=%h", i, pc_target_o, m_target); end
      end
      n_checks++; if (cnt_branches_o !== CNT_W'(m_br) || cnt_taken_o !== CNT_W'(m_tk) || cnt_jumps_o !== CNT_W'(m_jp)) begin n_errors++; $display("FAIL rnd_cnts cyc=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", i, cnt_branches_o, cnt_taken_o, cnt_jumps_o, m_br, m_tk, m_jp); end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 3'b010, 0, 32'h0, 0);
    #2;
    test_reset();
    test_taken_beq();
    test_not_taken();
    test_jump_stall();
    test_redir_stall();
    test_reset_in_squash();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
